// File: rtl/pe_cntl.sv
// Per-PE loop-nest sequencer: walks input channels (outer) and filter groups (inner),
// issuing one input/weight stream request at a time and waiting on the PPU between groups.
package pe_cntl_pkg;
    localparam int unsigned MAX_NUM_CHANNEL = 4;
    localparam int unsigned MAX_SIZE_OUTPUT = 64;
    localparam int unsigned NUM_LAYERS      = 2;
    localparam int unsigned CH_W            = $clog2(MAX_NUM_CHANNEL);
    localparam int unsigned CB_W            = CH_W + 1;
    localparam int unsigned NUM_W           = $clog2(MAX_SIZE_OUTPUT);
    localparam int unsigned K_W             = 8;
    localparam int unsigned PE_ID_W         = 4;
    localparam int unsigned BND_W           = 8;
    localparam int unsigned DIM_W           = 8;

    typedef struct packed {
        logic [K_W-1:0]             k_Conv_Boundary;
        logic [CB_W-1:0]            c_Conv_Boundary;
        logic [NUM_W-1:0]           num_of_compressed_weight;
        logic [MAX_NUM_CHANNEL-1:0] valid_channel;
        logic [MAX_NUM_CHANNEL-1:0] data_flow_channel;
        logic [BND_W-1:0]           w_Conv_Boundary;
        logic [BND_W-1:0]           a_Conv_Boundary;
        logic [DIM_W-1:0]           Size_of_R;
        logic [DIM_W-1:0]           Size_of_S;
        logic [DIM_W-1:0]           Size_of_W;
        logic [DIM_W-1:0]           Size_of_H;
    } conv_filter_parameter_t;

    typedef struct packed {
        logic               req_input;
        logic               req_filter;
        logic [PE_ID_W-1:0] pe_id;
        logic [CH_W-1:0]    channel_idx;
        logic [K_W-1:0]     k_idx;
        logic [NUM_W-1:0]   num_data;
        logic               data_flow;
        logic               busy;
        logic               layer_done;
    } req_stream_t;
endpackage

module pe_cntl
    import pe_cntl_pkg::*;
#(
    parameter int unsigned PE_num = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_W-1:0]       num_of_compressed_data [MAX_NUM_CHANNEL],
    input  conv_filter_parameter_t Conv_filter_Parameter_TB [NUM_LAYERS],
    input  logic                   PPU_finish_en,
    input  logic                   Stream_filter_finish,
    input  logic                   Stream_input_finish_PE,
    output req_stream_t            Req_Stream_PE
);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_REQ_INPUT  = 3'd1;
    localparam logic [2:0] ST_REQ_FILTER = 3'd2;
    localparam logic [2:0] ST_WAIT_PPU   = 3'd3;
    localparam logic [2:0] ST_DONE       = 3'd4;

    conv_filter_parameter_t cfg;
    logic [2:0]        state_q, state_d;
    logic [CH_W-1:0]   c_q, c_d;
    logic [K_W-1:0]    k_q, k_d;
    req_stream_t       req_q, req_d;
    logic [CH_W:0]     first_ch, next_ch;
    logic [K_W:0]      k_eff;
    logic              k_more;
    logic              unused_cfg;

    assign cfg = Conv_filter_Parameter_TB[0];

    // Returns {found, index} of the lowest enabled channel in [start, bound).
    function automatic logic [CH_W:0] find_channel(
        input logic [CB_W-1:0]            start,
        input logic [CB_W-1:0]            bound,
        input logic [MAX_NUM_CHANNEL-1:0] valid
    );
        logic [CH_W:0] res;
        res = '0;
        for (int i = 0; i < int'(MAX_NUM_CHANNEL); i++) begin
            if (!res[CH_W] && valid[i] && (CB_W'(i) >= start) && (CB_W'(i) < bound)) begin
                res = {1'b1, CH_W'(i)};
            end
        end
        return res;
    endfunction

    assign first_ch = find_channel('0, cfg.c_Conv_Boundary, cfg.valid_channel);
    assign next_ch  = find_channel(CB_W'(c_q) + CB_W'(1), cfg.c_Conv_Boundary, cfg.valid_channel);

    // A zero group count behaves as a single group.
    assign k_eff  = (cfg.k_Conv_Boundary == '0) ? (K_W+1)'(1) : {1'b0, cfg.k_Conv_Boundary};
    assign k_more = ({1'b0, k_q} + (K_W+1)'(1)) < k_eff;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            c_q     <= '0;
            k_q     <= '0;
            req_q   <= '0;
            req_q.pe_id <= PE_ID_W'(PE_num);
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            k_q     <= k_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        k_d     = k_q;
        case (state_q)
            ST_IDLE: begin
                c_d     = '0;
                k_d     = '0;
                state_d = ST_DONE;
                if (first_ch[CH_W]) begin
                    c_d     = first_ch[CH_W-1:0];
                    state_d = ST_REQ_INPUT;
                end
            end
            ST_REQ_INPUT: begin
                if (Stream_input_finish_PE) begin
                    k_d     = '0;
                    state_d = ST_REQ_FILTER;
                end
            end
            ST_REQ_FILTER: begin
                if (Stream_filter_finish) begin
                    state_d = ST_WAIT_PPU;
                end
            end
            ST_WAIT_PPU: begin
                if (PPU_finish_en) begin
                    if (k_more) begin
                        k_d     = k_q + K_W'(1);
                        state_d = ST_REQ_FILTER;
                    end else begin
                        k_d     = '0;
                        state_d = ST_DONE;
                        if (next_ch[CH_W]) begin
                            c_d     = next_ch[CH_W-1:0];
                            state_d = ST_REQ_INPUT;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bundle is built from the next state so it is registered without an extra cycle of lag.
    always_comb begin
        req_d             = '0;
        req_d.pe_id       = PE_ID_W'(PE_num);
        req_d.channel_idx = c_d;
        req_d.k_idx       = k_d;
        req_d.req_input   = (state_d == ST_REQ_INPUT);
        req_d.req_filter  = (state_d == ST_REQ_FILTER);
        req_d.busy        = (state_d == ST_REQ_INPUT) || (state_d == ST_REQ_FILTER) ||
                            (state_d == ST_WAIT_PPU);
        req_d.layer_done  = (state_d == ST_DONE);
        req_d.data_flow   = (state_d != ST_IDLE) && cfg.data_flow_channel[c_d];
        if (state_d == ST_REQ_INPUT) begin
            req_d.num_data = num_of_compressed_data[c_d];
        end else if (state_d == ST_REQ_FILTER) begin
            req_d.num_data = cfg.num_of_compressed_weight;
        end
    end

    assign Req_Stream_PE = req_q;

    assign unused_cfg = ^{cfg.w_Conv_Boundary, cfg.a_Conv_Boundary, cfg.Size_of_R,
                          cfg.Size_of_S, cfg.Size_of_W, cfg.Size_of_H,
                          Conv_filter_Parameter_TB[1]};

endmodule

// File: tb/tb_pe_cntl.sv
// Directed bench for pe_cntl: reset, handshakes, channel rollover, completion,
// ignored strobes, channel skipping, degenerate boundaries and mid-run reset.
module tb_pe_cntl;
    import pe_cntl_pkg::*;

    localparam int unsigned PE_PARAM = 3;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NUM_W-1:0]       ncd [MAX_NUM_CHANNEL];
    conv_filter_parameter_t cfg [NUM_LAYERS];
    logic                   ppu_fin = 1'b0;
    logic                   flt_fin = 1'b0;
    logic                   inp_fin = 1'b0;
    req_stream_t            req;

    int checks = 0;
    int passes = 0;

    pe_cntl #(.PE_num(PE_PARAM)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .num_of_compressed_data  (ncd),
        .Conv_filter_Parameter_TB(cfg),
        .PPU_finish_en           (ppu_fin),
        .Stream_filter_finish    (flt_fin),
        .Stream_input_finish_PE  (inp_fin),
        .Req_Stream_PE           (req)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic ri, input logic rf, input int ch,
                       input int k, input int nd, input logic df, input logic busy,
                       input logic done);
        req_stream_t e;
        e             = '0;
        e.req_input   = ri;
        e.req_filter  = rf;
        e.pe_id       = PE_ID_W'(PE_PARAM);
        e.channel_idx = CH_W'(ch);
        e.k_idx       = K_W'(k);
        e.num_data    = NUM_W'(nd);
        e.data_flow   = df;
        e.busy        = busy;
        e.layer_done  = done;
        checks++;
        assert (req === e) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, req, e);
    endtask

    task automatic chk_done(input string tag);
        logic [3:0] obs;
        obs = {req.req_input, req.req_filter, req.busy, req.layer_done};
        checks++;
        assert (obs === 4'b0001) passes++;
        else $error("FAIL %s: observed ri/rf/busy/done %b expected 0001", tag, obs);
    endtask

    task automatic pulse(input int which);
        case (which)
            0: inp_fin = 1'b1;
            1: flt_fin = 1'b1;
            2: ppu_fin = 1'b1;
            default: begin
                inp_fin = 1'b1;
                flt_fin = 1'b1;
                ppu_fin = 1'b1;
            end
        endcase
        tick();
        inp_fin = 1'b0;
        flt_fin = 1'b0;
        ppu_fin = 1'b0;
    endtask

    // Expects REQ_FILTER at (ch,k); completes the weight stream and the PPU drain.
    task automatic filter_round(input string tag, input int ch, input int k, input logic df);
        chk({tag, "_filter"}, 1'b0, 1'b1, ch, k, 4, df, 1'b1, 1'b0);
        pulse(1);
        chk({tag, "_wait"}, 1'b0, 1'b0, ch, k, 0, df, 1'b1, 1'b0);
        pulse(2);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) tick();
        chk("reset_state", 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
    endtask

    initial begin
        ncd[0] = NUM_W'(16);
        ncd[1] = NUM_W'(20);
        ncd[2] = NUM_W'(24);
        ncd[3] = NUM_W'(28);
        cfg[0] = '0;
        cfg[1] = '0;
        cfg[0].k_Conv_Boundary          = K_W'(8);
        cfg[0].c_Conv_Boundary          = CB_W'(3);
        cfg[0].valid_channel            = 4'b0111;
        cfg[0].num_of_compressed_weight = NUM_W'(4);
        cfg[0].data_flow_channel        = 4'b0101;

        // Reset and start
        tick();
        do_reset(1);
        chk("start_input", 1'b1, 1'b0, 0, 0, 16, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        chk("input_held", 1'b1, 1'b0, 0, 0, 16, 1'b1, 1'b1, 1'b0);
        pulse(1);
        pulse(2);
        chk("input_ignores_others", 1'b1, 1'b0, 0, 0, 16, 1'b1, 1'b1, 1'b0);

        // Basic handshake with ignored strobes
        pulse(0);
        chk("filter_k0", 1'b0, 1'b1, 0, 0, 4, 1'b1, 1'b1, 1'b0);
        pulse(2);
        pulse(0);
        chk("filter_ignores_ppu", 1'b0, 1'b1, 0, 0, 4, 1'b1, 1'b1, 1'b0);
        pulse(1);
        chk("wait_ppu", 1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
        pulse(1);
        pulse(0);
        chk("wait_ignores_stream", 1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
        pulse(2);
        chk("filter_k1", 1'b0, 1'b1, 0, 1, 4, 1'b1, 1'b1, 1'b0);
        // All strobes together: only the weight-stream finish acts in REQ_FILTER
        pulse(3);
        chk("multi_strobe_filter", 1'b0, 1'b0, 0, 1, 0, 1'b1, 1'b1, 1'b0);
        pulse(2);
        for (int k = 2; k < 8; k++) filter_round("ch0", 0, k, 1'b1);

        // Channel rollover
        chk("rollover_ch1", 1'b1, 1'b0, 1, 0, 20, 1'b0, 1'b1, 1'b0);
        pulse(0);
        for (int k = 0; k < 8; k++) filter_round("ch1", 1, k, 1'b0);
        chk("rollover_ch2", 1'b1, 1'b0, 2, 0, 24, 1'b1, 1'b1, 1'b0);
        pulse(0);
        for (int k = 0; k < 8; k++) filter_round("ch2", 2, k, 1'b1);

        // Layer completion, held for 100 cycles with strobes ignored
        chk_done("layer_done");
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 10; j++) begin
                if (j == 3) pulse(3);
                else tick();
            end
            chk_done("done_held");
        end

        // Mid-run reset at k=5
        do_reset(1);
        chk("restart_input", 1'b1, 1'b0, 0, 0, 16, 1'b1, 1'b1, 1'b0);
        pulse(0);
        for (int k = 0; k < 5; k++) filter_round("pre_rst", 0, k, 1'b1);
        chk("at_k5", 1'b0, 1'b1, 0, 5, 4, 1'b1, 1'b1, 1'b0);
        do_reset(1);
        chk("after_mid_reset", 1'b1, 1'b0, 0, 0, 16, 1'b1, 1'b1, 1'b0);

        // Channel 1 disabled: skipped, completion after 16 rounds
        rst = 1'b1;
        cfg[0].valid_channel = 4'b0101;
        do_reset(2);
        chk("skip_start", 1'b1, 1'b0, 0, 0, 16, 1'b1, 1'b1, 1'b0);
        pulse(0);
        for (int k = 0; k < 8; k++) filter_round("skip_ch0", 0, k, 1'b1);
        chk("skip_to_ch2", 1'b1, 1'b0, 2, 0, 24, 1'b1, 1'b1, 1'b0);
        pulse(0);
        for (int k = 0; k < 8; k++) filter_round("skip_ch2", 2, k, 1'b1);
        chk_done("skip_done");

        // k boundary 0 acts as 1; first channel skipped; c boundary stops at channel 2
        rst = 1'b1;
        cfg[0].k_Conv_Boundary = '0;
        cfg[0].c_Conv_Boundary = CB_W'(2);
        cfg[0].valid_channel   = 4'b0110;
        do_reset(1);
        chk("k0_start_ch1", 1'b1, 1'b0, 1, 0, 20, 1'b0, 1'b1, 1'b0);
        pulse(0);
        filter_round("k0_ch1", 1, 0, 1'b0);
        chk_done("k0_cbound_done");

        // c boundary 0: straight to DONE
        rst = 1'b1;
        cfg[0].c_Conv_Boundary = '0;
        cfg[0].valid_channel   = 4'b1111;
        do_reset(1);
        chk_done("c0_done");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
